gf727_dot_acc: RTL and testbench

Streaming modular dot-product engine over GF(727). Accepts operand pairs on a valid/ready stream, forms each 20-bit product, reduces it mod 727 in a pipelined Barrett stage, and accumulates the reduced terms mod 727. On the beat flagged last, it emits one canonical 10-bit sum on a valid/ready output. It sits upstream of the downstream GF(727) arithmetic consumers and feeds them canonical residues.

---
 rtl/gf727_pkg.sv | 33 +++
 rtl/gf727_dot_acc_if.sv | 35 +++
 rtl/gf727_prod_reduce.sv | 57 +++++
 rtl/gf727_dot_acc.sv | 119 +++++++++++
 tb/tb_gf727_dot_acc.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gf727_pkg.sv
// ---------------------------------------------------------------------------
// gf727_pkg
// Shared constants and types for the GF(727) dot-product engine.
//   Q / MU / DW / PW     : field modulus, Barrett multiplier, residue and
//                          product widths
//   BAR_SH1 / BAR_SH2    : Barrett pre/post shift amounts
//   dot_state_t          : engine FSM state (exposed on the debug port)
//   add_mod()            : canonical modular add of two residues
// ---------------------------------------------------------------------------
package gf727_pkg;

   localparam int Q       = 727;
   localparam int MU      = 1442;   // floor(2^20 / 727)
   localparam int DW      = 10;
   localparam int PW      = 20;
   localparam int BAR_SH1 = 9;
   localparam int BAR_SH2 = 11;

   typedef enum logic {
      ACC   = 1'b0,
      DRAIN = 1'b1
   } dot_state_t;

   // Both inputs canonical, so one conditional subtraction suffices.
   function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (DW+1)'(Q)) s = s - (DW+1)'(Q);
      return s[DW-1:0];
   endfunction

endpackage

// File: rtl/gf727_dot_acc_if.sv
// ---------------------------------------------------------------------------
// gf727_dot_acc_if
// Operand input stream and result output stream of gf727_dot_acc.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the source holds its payload stable while valid is high and
// ready is low, and ready never depends combinationally on valid.
//   master : stream source / result sink (testbench or upstream logic)
//   slave  : the engine
// Optional macro GF727_DOT_RANGE_CHK_EN adds the out_err signal.
// ---------------------------------------------------------------------------
import gf727_pkg::*;

interface gf727_dot_acc_if;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_sum;
`ifdef GF727_DOT_RANGE_CHK_EN
   logic          out_err;

   modport master (output in_valid, in_a, in_b, in_last, out_ready,
                   input  in_ready, out_valid, out_sum, out_err);
   modport slave  (input  in_valid, in_a, in_b, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_err);
`else
   modport master (output in_valid, in_a, in_b, in_last, out_ready,
                   input  in_ready, out_valid, out_sum);
   modport slave  (input  in_valid, in_a, in_b, in_last, out_ready,
                   output in_ready, out_valid, out_sum);
`endif
endinterface

// File: rtl/gf727_prod_reduce.sv
// ---------------------------------------------------------------------------
// gf727_prod_reduce
// Registered Barrett reduction of a 20-bit product modulo 727.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_prod     : product, valid result guaranteed for i_prod <= 726*726
//   i_vld      : i_prod valid
//   i_last     : i_prod belongs to the last beat of a vector
//   o_red      : i_prod mod 727, canonical, one cycle later
//   o_vld      : registered i_vld
//   o_last     : registered i_last
// ---------------------------------------------------------------------------
import gf727_pkg::*;

module gf727_prod_reduce (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [PW-1:0] i_prod,
   input  logic          i_vld,
   input  logic          i_last,
   output logic [DW-1:0] o_red,
   output logic          o_vld,
   output logic          o_last
);

   logic [PW-BAR_SH1-1:0] w_q1;
   logic [21:0]           w_m;
   logic [21:0]           w_m_sh;
   logic [10:0]           w_t;
   logic [21:0]           w_tq;
   logic [11:0]           w_r0;
   logic [11:0]           w_r1;
   logic [11:0]           w_r2;

   assign w_q1   = i_prod[PW-1:BAR_SH1];
   assign w_m    = {11'd0, w_q1} * 22'(MU);
   assign w_m_sh = w_m >> BAR_SH2;
   assign w_t    = w_m_sh[10:0];        // quotient estimate, <= 724
   assign w_tq   = {11'd0, w_t} * 22'(Q);
   // The true remainder lies below 3*Q < 4096, so 12-bit wrap-around
   // subtraction on the low bits yields it exactly.
   assign w_r0   = i_prod[11:0] - w_tq[11:0];
   assign w_r1   = (w_r0 >= 12'(Q)) ? (w_r0 - 12'(Q)) : w_r0;
   assign w_r2   = (w_r1 >= 12'(Q)) ? (w_r1 - 12'(Q)) : w_r1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_red  <= '0;
         o_vld  <= 1'b0;
         o_last <= 1'b0;
      end else begin
         o_vld  <= i_vld;
         o_last <= i_vld & i_last;
         if (i_vld) o_red <= w_r2[DW-1:0];
      end
   end

endmodule

// File: rtl/gf727_dot_acc.sv
// ---------------------------------------------------------------------------
// gf727_dot_acc
// Streaming dot product over GF(727): sum of a*b mod 727 per vector.
// Pipeline: P (multiply) -> R (Barrett, sub-module) -> A (accumulate).
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave side of gf727_dot_acc_if (operand/result streams)
//   o_dbg_state : current FSM state
// Optional macro GF727_DOT_RANGE_CHK_EN: operands >= 727 are zeroed and a
// sticky out_err is reported with the result.
// ---------------------------------------------------------------------------
import gf727_pkg::*;

module gf727_dot_acc (
   input  logic            clk,
   input  logic            rst_n,
   gf727_dot_acc_if.slave  bus,
   output dot_state_t      o_dbg_state
);

   dot_state_t    r_state;
   logic [PW-1:0] r_prod;
   logic          r_vld_p;
   logic          r_last_p;
   logic [DW-1:0] r_acc;
   logic          r_done;       // last term entered the accumulator
   logic          r_out_valid;

   logic          w_accept;
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic [DW-1:0] w_red;
   logic          w_vld_r;
   logic          w_last_r;

   assign w_accept = bus.in_valid & bus.in_ready;

`ifdef GF727_DOT_RANGE_CHK_EN
   logic r_err;
   logic w_bad_a;
   logic w_bad_b;
   assign w_bad_a     = (bus.in_a >= DW'(Q));
   assign w_bad_b     = (bus.in_b >= DW'(Q));
   assign w_a         = w_bad_a ? '0 : bus.in_a;
   assign w_b         = w_bad_b ? '0 : bus.in_b;
   assign bus.out_err = r_err;
`else
   assign w_a = bus.in_a;
   assign w_b = bus.in_b;
`endif

   // Stage P
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod   <= '0;
         r_vld_p  <= 1'b0;
         r_last_p <= 1'b0;
      end else begin
         r_vld_p  <= w_accept;
         r_last_p <= w_accept & bus.in_last;
         if (w_accept) r_prod <= PW'(w_a) * PW'(w_b);
      end
   end

   // Stage R
   gf727_prod_reduce u_reduce (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_prod (r_prod),
      .i_vld  (r_vld_p),
      .i_last (r_last_p),
      .o_red  (w_red),
      .o_vld  (w_vld_r),
      .o_last (w_last_r)
   );

   // Stage A and FSM. out_valid rises one edge after the last term lands in
   // r_acc, so out_sum (= r_acc) is final and stays put while out_valid is
   // high: no terms are in flight once DRAIN has seen r_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACC;
         r_acc       <= '0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef GF727_DOT_RANGE_CHK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         if (w_vld_r) r_acc <= add_mod(r_acc, w_red);
         r_done <= w_vld_r & w_last_r;
`ifdef GF727_DOT_RANGE_CHK_EN
         if (w_accept && (w_bad_a || w_bad_b)) r_err <= 1'b1;
`endif
         case (r_state)
            ACC: begin
               if (w_accept && bus.in_last) r_state <= DRAIN;
            end
            DRAIN: begin
               if (r_done) r_out_valid <= 1'b1;
               if (r_out_valid && bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_state     <= ACC;
`ifdef GF727_DOT_RANGE_CHK_EN
                  r_err       <= 1'b0;
`endif
               end
            end
            default: r_state <= ACC;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ACC);
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_acc;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_gf727_dot_acc.sv
import gf727_pkg::*;

module tb_gf727_dot_acc;

  logic       clk;
  logic       rst_n;
  dot_state_t dbg_state;
  int         cyc;
  int         errors;
  int         checks;
  int         last_acc_cyc;
  logic       prev_vld;
  logic [10:0] exp_q[$];   // {err, sum}

  gf727_dot_acc_if bus ();

  gf727_dot_acc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int sum, input bit err);
    exp_q.push_back({err, 10'(sum)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int a, input int b, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = 10'(a);
    bus.in_b     = 10'(b);
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_wait", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    if (last) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_timeout_pending", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.out_valid && !prev_vld)
        check("latency", cyc - last_acc_cyc, 3);
      prev_vld = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("out_sum", int'(bus.out_sum), int'(e[9:0]));
`ifdef GF727_DOT_RANGE_CHK_EN
          check("out_err", int'(bus.out_err), int'(e[10]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic saw;
    errors       = 0;
    checks       = 0;
    last_acc_cyc = 0;
    prev_vld     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sum", int'(bus.out_sum), 0);
    check("rst_state", int'(dbg_state), int'(ACC));
`ifdef GF727_DOT_RANGE_CHK_EN
    check("rst_out_err", int'(bus.out_err), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single beat, maximal operands: 726*726 mod 727 = 1
    push_exp(1, 0);
    send(726, 726, 1);
    @(negedge clk);
    check("in_ready_after_last", int'(bus.in_ready), 0);
    wait_drain();

    // back-to-back: 6 + 20 = 26
    push_exp(26, 0);
    send(2, 3, 0);
    send(4, 5, 1);
    wait_drain();

    // wrap to zero: 726 + 1 = 727 -> 0
    push_exp(0, 0);
    send(726, 1, 0);
    send(1, 1, 1);
    wait_drain();

    // (1000 + 900) mod 727 = 446
    push_exp(446, 0);
    send(500, 2, 0);
    send(300, 3, 1);
    wait_drain();

    // backpressure: 10*10 = 100 held for 5 cycles
    bus.out_ready = 1'b0;
    push_exp(100, 0);
    send(10, 10, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_sum_stable", int'(bus.out_sum), 100);
      check("bp_in_ready_low", int'(bus.in_ready), 0);
      check("bp_out_valid_held", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    wait_drain();
    push_exp(1, 0);
    send(1, 1, 1);
    wait_drain();

    // reset in the middle of a vector discards it
    send(5, 5, 0);
    send(6, 6, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | bus.out_valid;
    end
    check("midrst_no_output", int'(saw), 0);
    @(posedge clk); #1;
    push_exp(9, 0);
    send(3, 3, 1);
    wait_drain();

`ifdef GF727_DOT_RANGE_CHK_EN
    // out-of-range operand zeroed: 0*5 + 2*2 = 4, error flagged
    push_exp(4, 1);
    send(800, 5, 0);
    send(2, 2, 1);
    wait_drain();
    push_exp(2, 0);
    send(1, 2, 1);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
